// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bubble/halt encodings, fetch FSM states,
// control-bus width and opcode field position used across the stages.
package pipeline_pkg;

  localparam logic [31:0] NOP_WORD   = 32'h6800_0000;
  localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
  localparam int          CTRL_BUS_W = 22;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 27;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  // Extract the 5-bit opcode field of an instruction word.
  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/if_of_latch.sv
// Generic {PC, IR, valid} pipeline latch. Flush loads the bubble word and
// clears valid (the PC field keeps its old value, it is meaningless then);
// hold keeps the whole latch. Flush wins over hold.
module if_of_latch
  import pipeline_pkg::*;
#(
  parameter logic [31:0] FLUSH_WORD = pipeline_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_ir,
  output logic [31:0] q_pc,
  output logic [31:0] q_ir,
  output logic        q_valid
);

  // Latch register: reset, flush to bubble, hold, or load new {PC, IR}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pc    <= 32'h0000_0000;
      q_ir    <= FLUSH_WORD;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_ir    <= FLUSH_WORD;
      q_valid <= 1'b0;
    end else if (hold) begin
      q_pc    <= q_pc;
      q_ir    <= q_ir;
      q_valid <= q_valid;
    end else begin
      q_pc    <= d_pc;
      q_ir    <= d_ir;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address, fills the IF/OF latch, and after fetching the halt word lets the
// pipeline drain before raising a sticky isLastInstruction.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int          IMEM_AW      = 10,
  parameter logic [31:0] HALT_WORD    = pipeline_pkg::HALT_WORD,
  parameter logic [31:0] NOP_WORD     = pipeline_pkg::NOP_WORD,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               is_Branch_Taken,
  input  logic [31:0]        branchPC,
  input  logic               isDataInterLock,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        PC,
  output logic [31:0]        IR,
  output logic [31:0]        input_OF_PC,
  output logic [31:0]        Input_OF_IR,
  output logic               of_valid,
  output logic               isLastInstruction
);

  localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  fetch_state_e     state_r;
  logic [31:0]      pc_r;
  logic [CNT_W-1:0] drain_cnt_r;
  logic             last_r;
  logic             flush_s;
  logic             hold_s;
  logic             is_halt_s;
  logic [31:0]      target_s;

  assign is_halt_s = (imem_rdata == HALT_WORD);
  // Branch targets are word aligned; low two bits of the EX target are dropped.
  assign target_s  = branchPC & 32'hFFFF_FFFC;

  assign PC                = pc_r;
  assign IR                = imem_rdata;
  assign imem_addr         = pc_r[IMEM_AW+1:2];
  assign isLastInstruction = last_r;

  // Latch control: branch flushes (older than any stall), interlock holds,
  // drain and halted states feed bubbles, otherwise load the fetched word.
  always_comb begin
    flush_s = 1'b0;
    hold_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (is_Branch_Taken) begin
          flush_s = 1'b1;
        end else if (isDataInterLock) begin
          hold_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (is_Branch_Taken) begin
          flush_s = 1'b1;
        end else if (isDataInterLock) begin
          hold_s = 1'b1;
        end else begin
          flush_s = 1'b1;
        end
      end
      ST_HALTED: flush_s = 1'b1;
      default:   flush_s = 1'b1;
    endcase
  end

  // Fetch FSM: PC update, halt detection, drain countdown, sticky halt flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_RUN;
      pc_r        <= 32'h0000_0000;
      drain_cnt_r <= '0;
      last_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (is_Branch_Taken) begin
            pc_r        <= target_s;
            drain_cnt_r <= '0;
          end else if (isDataInterLock) begin
            pc_r <= pc_r;
          end else if (is_halt_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            pc_r <= pc_r + 32'd4;
          end
        end
        ST_DRAIN: begin
          if (is_Branch_Taken) begin
            state_r     <= ST_RUN;
            pc_r        <= target_s;
            drain_cnt_r <= '0;
          end else if (isDataInterLock) begin
            drain_cnt_r <= drain_cnt_r;
          end else if (drain_cnt_r == '0) begin
            state_r <= ST_HALTED;
            last_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - 1'b1;
          end
        end
        ST_HALTED: begin
          last_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_RUN;
          drain_cnt_r <= '0;
        end
      endcase
    end
  end

  if_of_latch #(
    .FLUSH_WORD(NOP_WORD)
  ) u_if_of_latch (
    .clk    (clk),
    .rst_n  (reset),
    .hold   (hold_s),
    .flush  (flush_s),
    .d_pc   (pc_r),
    .d_ir   (imem_rdata),
    .q_pc   (input_OF_PC),
    .q_ir   (Input_OF_IR),
    .q_valid(of_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver pushes hand-computed expected
// outputs for each edge, a monitor pops and compares on the falling edge.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        is_Branch_Taken;
  logic [31:0] branchPC;
  logic        isDataInterLock;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] IR;
  logic [31:0] input_OF_PC;
  logic [31:0] Input_OF_IR;
  logic        of_valid;
  logic        isLastInstruction;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ofpc;
    logic [31:0] ofir;
    logic        v;
    logic        last;
    logic        chk_ofpc;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  event chk_ev;

  localparam logic [31:0] NOP  = 32'h6800_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .is_Branch_Taken  (is_Branch_Taken),
    .branchPC         (branchPC),
    .isDataInterLock  (isDataInterLock),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .PC               (PC),
    .IR               (IR),
    .input_OF_PC      (input_OF_PC),
    .Input_OF_IR      (Input_OF_IR),
    .of_valid         (of_valid),
    .isLastInstruction(isLastInstruction)
  );

  assign imem_rdata = mem[imem_addr];

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t        e;
    logic [31:0] mexp;
    logic        ok;
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        mexp = mem[e.pc[11:2]];
        ok   = (PC == e.pc) && (Input_OF_IR == e.ofir) && (of_valid == e.v) &&
               (isLastInstruction == e.last) && (imem_addr == e.pc[11:2]) &&
               (IR == mexp) && (!e.chk_ofpc || (input_OF_PC == e.ofpc));
        n_vec++;
        if (!ok) begin
          n_err++;
          $display("FAIL %s: got pc=%h addr=%h ir=%h ofpc=%h ofir=%h v=%b last=%b ; want pc=%h ir=%h ofpc=%h ofir=%h v=%b last=%b",
                   e.nm, PC, imem_addr, IR, input_OF_PC, Input_OF_IR, of_valid,
                   isLastInstruction, e.pc, mexp, e.ofpc, e.ofir, e.v, e.last);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want run to finish");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] ofpc,
                      input logic [31:0] ofir, input logic v, input logic last,
                      input logic chk, input string nm);
    exp_t e;
    e.pc = pc; e.ofpc = ofpc; e.ofir = ofir; e.v = v; e.last = last;
    e.chk_ofpc = chk; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // One clock edge with given inputs; expectation is for the state after it.
  task automatic step(input logic br, input logic [31:0] bpc, input logic il,
                      input logic [31:0] pc, input logic [31:0] ofpc,
                      input logic [31:0] ofir, input logic v, input logic last,
                      input string nm);
    is_Branch_Taken = br;
    branchPC        = bpc;
    isDataInterLock = il;
    push(pc, ofpc, ofir, v, last, v, nm);
    @(posedge clk);
    @(negedge clk);
    #1;
    is_Branch_Taken = 1'b0;
    branchPC        = 32'h0;
    isDataInterLock = 1'b0;
  endtask

  // Assert reset between edges, check outputs immediately, release later.
  task automatic do_reset(input string nm);
    reset = 1'b0;
    #2;
    push(32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b1, nm);
    -> chk_ev;
    #1;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Run from reset up to and including the edge that fetches the halt word.
  task automatic run_to_halt(input string tag);
    step(0, 0, 0, 32'd4,  32'd0,  32'h1000_0001, 1, 0, {tag, "_f0"});
    step(0, 0, 0, 32'd8,  32'd4,  32'h1000_0002, 1, 0, {tag, "_f1"});
    step(0, 0, 0, 32'd12, 32'd8,  32'h1000_0003, 1, 0, {tag, "_f2"});
    step(0, 0, 0, 32'd16, 32'd12, 32'h1000_0004, 1, 0, {tag, "_f3"});
    step(0, 0, 0, 32'd20, 32'd16, 32'h1000_0005, 1, 0, {tag, "_f4"});
    step(0, 0, 0, 32'd20, 32'd20, HALT,          1, 0, {tag, "_halt"});
  endtask

  // Directed stimulus.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]  = 32'h1000_0001;
    mem[1]  = 32'h1000_0002;
    mem[2]  = 32'h1000_0003;
    mem[3]  = 32'h1000_0004;
    mem[4]  = 32'h1000_0005;
    mem[5]  = HALT;
    mem[16] = 32'h2000_0010;
    mem[64] = 32'h3000_0040;
    mem[65] = 32'h3000_0041;
    is_Branch_Taken = 1'b0;
    branchPC        = 32'h0;
    isDataInterLock = 1'b0;
    reset           = 1'b1;
    #1;

    // Test 1: reset then straight-line fetch.
    do_reset("reset0");
    step(0, 0, 0, 32'd4,  32'd0,  32'h1000_0001, 1, 0, "line0");
    step(0, 0, 0, 32'd8,  32'd4,  32'h1000_0002, 1, 0, "line1");
    step(0, 0, 0, 32'd12, 32'd8,  32'h1000_0003, 1, 0, "line2");
    step(0, 0, 0, 32'd16, 32'd12, 32'h1000_0004, 1, 0, "line3");

    // Test 2: interlock for two cycles at PC=8.
    do_reset("reset1");
    step(0, 0, 0, 32'd4,  32'd0, 32'h1000_0001, 1, 0, "il_pre0");
    step(0, 0, 0, 32'd8,  32'd4, 32'h1000_0002, 1, 0, "il_pre1");
    step(0, 0, 1, 32'd8,  32'd4, 32'h1000_0002, 1, 0, "il_hold0");
    step(0, 0, 1, 32'd8,  32'd4, 32'h1000_0002, 1, 0, "il_hold1");
    step(0, 0, 0, 32'd12, 32'd8, 32'h1000_0003, 1, 0, "il_release");

    // Test 3: branch flush with misaligned target, then branch + interlock.
    step(1, 32'h41, 0, 32'h40, 32'd0,  NOP,           0, 0, "br_flush");
    step(0, 0,      0, 32'h44, 32'h40, 32'h2000_0010, 1, 0, "br_target");
    step(1, 32'h41, 1, 32'h40, 32'd0,  NOP,           0, 0, "br_over_il");
    step(0, 0,      0, 32'h44, 32'h40, 32'h2000_0010, 1, 0, "br_target2");

    // Test 4: halt, drain of exactly four edges, then frozen.
    do_reset("reset2");
    run_to_halt("h");
    step(0, 0, 0, 32'd20, 32'd0, NOP, 0, 0, "drain1");
    step(0, 0, 0, 32'd20, 32'd0, NOP, 0, 0, "drain2");
    step(0, 0, 0, 32'd20, 32'd0, NOP, 0, 0, "drain3");
    step(0, 0, 0, 32'd20, 32'd0, NOP, 0, 1, "drain4_last");
    step(1, 32'h100, 1, 32'd20, 32'd0, NOP, 0, 1, "halted_br");
    step(0, 0,       1, 32'd20, 32'd0, NOP, 0, 1, "halted_il");
    step(0, 0,       0, 32'd20, 32'd0, NOP, 0, 1, "halted_idle");

    // Test 5: branch on the second drain cycle cancels the halt.
    do_reset("reset3");
    run_to_halt("b");
    step(0, 0,       0, 32'd20,  32'd0,   NOP,           0, 0, "bd_drain1");
    step(1, 32'h100, 0, 32'h100, 32'd0,   NOP,           0, 0, "bd_branch");
    step(0, 0,       0, 32'h104, 32'h100, 32'h3000_0040, 1, 0, "bd_run0");
    step(0, 0,       0, 32'h108, 32'h104, 32'h3000_0041, 1, 0, "bd_run1");
    step(0, 0,       0, 32'h10C, 32'h108, 32'h0,         1, 0, "bd_run2");
    step(0, 0,       0, 32'h110, 32'h10C, 32'h0,         1, 0, "bd_run3");
    step(0, 0,       0, 32'h114, 32'h110, 32'h0,         1, 0, "bd_run4");

    // Test 6: asynchronous reset in the middle of the drain.
    do_reset("reset4");
    run_to_halt("r");
    step(0, 0, 0, 32'd20, 32'd0, NOP, 0, 0, "rd_drain1");
    step(0, 0, 0, 32'd20, 32'd0, NOP, 0, 0, "rd_drain2");
    do_reset("reset_middrain");
    step(0, 0, 0, 32'd4, 32'd0, 32'h1000_0001, 1, 0, "restart0");
    step(0, 0, 0, 32'd8, 32'd4, 32'h1000_0002, 1, 0, "restart1");

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
